// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 core: ALU modes, P bit positions, flag ops,
// branch selectors and ALU flag-update mask positions.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_SL  = 3'd5;
  localparam logic [2:0] ALU_SR  = 3'd6;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } flag_op_e;

  localparam logic [1:0] BR_SEL_N = 2'b00;
  localparam logic [1:0] BR_SEL_V = 2'b01;
  localparam logic [1:0] BR_SEL_C = 2'b10;
  localparam logic [1:0] BR_SEL_Z = 2'b11;

  localparam int M_C = 0;
  localparam int M_Z = 1;
  localparam int M_V = 2;
  localparam int M_N = 3;

endpackage

// File: rtl/nmi_edge.sv
// NMI falling-edge detector: sample flop plus pending latch cleared by ack.
module nmi_edge (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  input  logic nmi_ack,
  output logic nmi_pending
);

  logic nmi_q, nmi_d;
  logic pending_q, pending_d;

  always_comb begin
    nmi_d     = nmi_n;
    pending_d = pending_q;
    // A fresh edge takes precedence over an acknowledge in the same cycle.
    if (nmi_q && !nmi_n) pending_d = 1'b1;
    else if (nmi_ack)    pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q     <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      nmi_q     <= nmi_d;
      pending_q <= pending_d;
    end
  end

  assign nmi_pending = pending_q;

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register: delayed ALU flag commit, flag instructions,
// PLP/RTI load, push image, branch evaluation and interrupt pending flags.
module status_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_en,
  input  logic [3:0] upd_mask,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_din,
  input  logic       brk_push,
  input  logic [2:0] br_cond,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       br_taken,
  output logic       irq_pending,
  output logic       nmi_pending
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic       upd_q, upd_d;
  logic [3:0] mask_q, mask_d;
  logic       irq_pending_q, irq_pending_d;
  logic       br_flag;
  logic       unused_pdin;

  assign unused_pdin = ^p_din[5:4];

  // NOTE: every combinational output is defaulted first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    upd_d  = upd_en;
    mask_d = upd_mask;
    irq_pending_d = ~irq_n & ~i_q;

    if (upd_q) begin
      if (mask_q[M_N]) n_d = alu_out[7];
      if (mask_q[M_Z]) z_d = (alu_out == 8'h00);
      if (mask_q[M_V]) v_d = alu_overflow;
      if (mask_q[M_C]) c_d = alu_carry;
    end

    case (flag_op_e'(flag_op))
      FOP_CLC: c_d = 1'b0;
      FOP_SEC: c_d = 1'b1;
      FOP_CLI: i_d = 1'b0;
      FOP_SEI: i_d = 1'b1;
      FOP_CLV: v_d = 1'b0;
      FOP_CLD: d_d = 1'b0;
      FOP_SED: d_d = 1'b1;
      default: ;
    endcase

    // A pulled P replaces every stored flag, discarding any pending ALU commit.
    if (p_load) begin
      n_d = p_din[P_N];
      v_d = p_din[P_V];
      d_d = p_din[P_D];
      i_d = p_din[P_I];
      z_d = p_din[P_Z];
      c_d = p_din[P_C];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
      upd_q  <= 1'b0;
      mask_q <= 4'b0000;
      irq_pending_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
      upd_q  <= upd_d;
      mask_q <= mask_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  always_comb begin
    case (br_cond[2:1])
      BR_SEL_N: br_flag = n_q;
      BR_SEL_V: br_flag = v_q;
      BR_SEL_C: br_flag = c_q;
      default:  br_flag = z_q;
    endcase
  end

  assign br_taken    = (br_flag == br_cond[0]);
  assign p_out       = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign p_push      = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign irq_pending = irq_pending_q;

  nmi_edge u_nmi_edge (
    .clk        (clk),
    .reset      (reset),
    .nmi_n      (nmi_n),
    .nmi_ack    (nmi_ack),
    .nmi_pending(nmi_pending)
  );

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg with hand-computed expected values.
module tb_status_reg;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd_en;
  logic [3:0] upd_mask;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       alu_overflow;
  logic [2:0] flag_op;
  logic       p_load;
  logic [7:0] p_din;
  logic       brk_push;
  logic [2:0] br_cond;
  logic       irq_n;
  logic       nmi_n;
  logic       nmi_ack;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       br_taken;
  logic       irq_pending;
  logic       nmi_pending;

  int checks = 0;
  int errors = 0;

  status_reg dut (
    .clk         (clk),
    .reset       (reset),
    .upd_en      (upd_en),
    .upd_mask    (upd_mask),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .flag_op     (flag_op),
    .p_load      (p_load),
    .p_din       (p_din),
    .brk_push    (brk_push),
    .br_cond     (br_cond),
    .irq_n       (irq_n),
    .nmi_n       (nmi_n),
    .nmi_ack     (nmi_ack),
    .p_out       (p_out),
    .p_push      (p_push),
    .br_taken    (br_taken),
    .irq_pending (irq_pending),
    .nmi_pending (nmi_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; upd_en = 1'b0; upd_mask = 4'h0; alu_out = 8'h00;
    alu_carry = 1'b0; alu_overflow = 1'b0; flag_op = FOP_NONE;
    p_load = 1'b0; p_din = 8'h00; brk_push = 1'b0; br_cond = 3'b000;
    irq_n = 1'b1; nmi_n = 1'b1; nmi_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_p_out", p_out, 8'h34);
    check("reset_push_irq", p_push, 8'h24);
    brk_push = 1'b1; #1;
    check("reset_push_brk", p_push, 8'h34);
    brk_push = 1'b0;
    check("reset_nmi_pend", {7'd0, nmi_pending}, 8'h00);
    check("reset_irq_pend", {7'd0, irq_pending}, 8'h00);
    reset = 1'b0;

    // 7F + 01: result 80, V=1, C=0; flags land two cycles after issue
    upd_en = 1'b1; upd_mask = 4'b1111;
    tick();
    upd_en = 1'b0; alu_out = 8'h80; alu_carry = 1'b0; alu_overflow = 1'b1;
    #1;
    check("add_t1_unchanged", p_out, 8'h34);
    tick();
    check("add_t2_flags", p_out, 8'hF4);
    br_cond = 3'b001; #1;
    check("br_n_set", {7'd0, br_taken}, 8'h01);
    br_cond = 3'b000; #1;
    check("br_n_clear", {7'd0, br_taken}, 8'h00);
    br_cond = 3'b011; #1;
    check("br_v_set", {7'd0, br_taken}, 8'h01);

    // Result 00 carry 1, mask N,Z,C (V held), SEC alongside
    upd_en = 1'b1; upd_mask = 4'b1011;
    tick();
    upd_en = 1'b0; alu_out = 8'h00; alu_carry = 1'b1; alu_overflow = 1'b0;
    flag_op = FOP_SEC;
    tick();
    flag_op = FOP_NONE;
    check("zero_sec", p_out, 8'h77);
    br_cond = 3'b111; #1;
    check("br_z_set", {7'd0, br_taken}, 8'h01);
    br_cond = 3'b110; #1;
    check("br_z_clear", {7'd0, br_taken}, 8'h00);

    // CLC overrides an ALU carry=1 in the same commit cycle; Z stays masked off
    upd_en = 1'b1; upd_mask = 4'b0001;
    tick();
    upd_en = 1'b0; alu_out = 8'h05; alu_carry = 1'b1; flag_op = FOP_CLC;
    tick();
    flag_op = FOP_NONE;
    check("clc_override", p_out, 8'h76);
    br_cond = 3'b101; #1;
    check("br_c_set", {7'd0, br_taken}, 8'h00);
    br_cond = 3'b100; #1;
    check("br_c_clear", {7'd0, br_taken}, 8'h01);

    // p_load beats a pending ALU commit; bits 5:4 of p_din ignored
    upd_en = 1'b1; upd_mask = 4'b1111;
    tick();
    upd_en = 1'b0; alu_out = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0;
    p_load = 1'b1; p_din = 8'hC3;
    tick();
    p_load = 1'b0;
    check("plp_load", p_out, 8'hF3);
    check("plp_push_irq", p_push, 8'hE3);

    // Back-to-back issues commit in order
    upd_en = 1'b1; upd_mask = 4'b0010;
    tick();
    upd_mask = 4'b0001; alu_out = 8'h05; alu_carry = 1'b1;
    tick();
    check("b2b_first_z", p_out, 8'hF1);
    upd_en = 1'b0; alu_carry = 1'b0;
    tick();
    check("b2b_second_c", p_out, 8'hF0);

    // Flag instructions
    flag_op = FOP_SEI; tick();
    check("sei", p_out, 8'hF4);
    flag_op = FOP_SED; tick();
    check("sed", p_out, 8'hFC);
    flag_op = FOP_CLD; tick();
    check("cld", p_out, 8'hF4);
    flag_op = FOP_CLV; tick();
    check("clv", p_out, 8'hB4);
    flag_op = FOP_NONE;

    // IRQ masked by I, released by CLI with one-cycle lag
    irq_n = 1'b0;
    tick(); tick();
    check("irq_masked", {7'd0, irq_pending}, 8'h00);
    flag_op = FOP_CLI;
    tick();
    flag_op = FOP_NONE;
    check("cli_p_out", p_out, 8'hB0);
    check("irq_lag", {7'd0, irq_pending}, 8'h00);
    tick();
    check("irq_pending", {7'd0, irq_pending}, 8'h01);

    // Reset mid-pending, also discarding an in-flight ALU commit
    upd_en = 1'b1; upd_mask = 4'b1111;
    tick();
    upd_en = 1'b0; reset = 1'b1; alu_out = 8'h80; alu_carry = 1'b1; alu_overflow = 1'b1;
    tick();
    check("rst_irq_pend", {7'd0, irq_pending}, 8'h00);
    check("rst_discard", p_out, 8'h34);
    tick();
    check("rst_held", p_out, 8'h34);
    reset = 1'b0; irq_n = 1'b1;
    tick();
    check("rst_no_commit", p_out, 8'h34);

    // NMI edge detection
    nmi_n = 1'b0;
    tick();
    check("nmi_edge", {7'd0, nmi_pending}, 8'h01);
    tick(); tick();
    check("nmi_held", {7'd0, nmi_pending}, 8'h01);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("nmi_ack_clear", {7'd0, nmi_pending}, 8'h00);
    tick(); tick();
    check("nmi_low_no_reedge", {7'd0, nmi_pending}, 8'h00);
    nmi_n = 1'b1;
    tick();
    check("nmi_rise", {7'd0, nmi_pending}, 8'h00);
    nmi_n = 1'b0;
    tick();
    check("nmi_second_edge", {7'd0, nmi_pending}, 8'h01);
    nmi_n = 1'b1; nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("nmi_ack2", {7'd0, nmi_pending}, 8'h00);
    nmi_n = 1'b0; nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("nmi_set_wins", {7'd0, nmi_pending}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_reg.md
# status_reg

Processor status (P) register stage directly downstream of the `alu` block in the NES 6502 core. It consumes the ALU's registered result, carry and overflow, and derives N and Z from the result byte itself. It applies per-instruction flag-update masks, explicit flag instructions and PLP/RTI loads, and provides the stack-push image and branch-condition evaluation. It also holds the NMI edge latch and masked IRQ pending flag for the sequencer.

## Interface
Parameters: none.

- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- upd_en  in  1  ALU op issued this cycle; its flags commit one cycle later
- upd_mask  in  4  {N,V,Z,C} flags the issued op updates
- alu_out  in  8  ALU registered result
- alu_carry  in  1  ALU `carry_out`
- alu_overflow  in  1  ALU `overflow`
- flag_op  in  3  NONE=0, CLC, SEC, CLI, SEI, CLV, CLD, SED=7
- p_load  in  1  load P from p_din (PLP/RTI)
- p_din  in  8  byte pulled from stack
- brk_push  in  1  1 = BRK/PHP push image, 0 = IRQ/NMI
- br_cond  in  3  opcode[7:5] of branch
- irq_n  in  1  IRQ line, level, active-low
- nmi_n  in  1  NMI line, edge, active-low
- nmi_ack  in  1  sequencer accepted NMI
- p_out  out  8  {N,V,1,1,D,I,Z,C}
- p_push  out  8  {N,V,1,brk_push,D,I,Z,C}
- br_taken  out  1  branch condition true
- irq_pending  out  1  IRQ asserted and I=0
- nmi_pending  out  1  latched NMI falling edge

## Operation
- Storage: six flops N,V,D,I,Z,C; bits 5/4 not stored.
- Reset: N=V=D=Z=C=0, I=1; p_out=8'h34; upd pipeline cleared; nmi_pending=0, irq_pending=0, nmi sample flop=1.
- ALU update pipeline: upd_en and upd_mask registered into upd_q/mask_q. When upd_q=1: N←alu_out[7], Z←(alu_out==0), V←alu_overflow, C←alu_carry, each only if its mask_q bit is set.
- flag_op: sets or clears a single flag.
- Priority per cycle: reset > p_load > flag_op > delayed ALU update. flag_op overrides only the flag it names; other masked ALU flags still commit.
- p_load: N,V,D,I,Z,C ← p_din[7,6,3,2,1,0]; p_din[5:4] ignored. A pending upd_q in the same cycle is discarded.
- br_taken: flag selected by br_cond[2:1] (00 N, 01 V, 10 C, 11 Z) compared with br_cond[0]. Combinational from stored P.
- NMI: nmi_q ← nmi_n each cycle. Set nmi_pending when nmi_q=1 and nmi_n=0. Clear on nmi_ack. A set in the same cycle as nmi_ack wins. A held-low NMI produces one edge only.
- IRQ: irq_pending ← ~irq_n & ~I, registered. Uses I before any same-cycle update.

## Timing
- ALU op issued cycle t: ALU result valid t+1; flags visible on p_out/br_taken at t+2.
- flag_op or p_load in cycle t: visible t+1.
- Back-to-back upd_en every cycle is supported; each commits in order, two cycles after issue.
- Sequencer must not evaluate br_taken for a branch dependent on an op issued at t before t+2.
- p_push is combinational; it reflects P at the cycle it is sampled.
- Reset asserted with upd_q=1 discards that update; reset held multiple cycles keeps all reset values.
- nmi_pending rises the cycle after the first sampled low; irq_pending lags irq_n/I by one cycle.

## Structure
- Shared package `cpu_pkg`:
  - ALU mode constants (ALU_ADD..ALU_SR)
  - P bit index constants (P_C=0 .. P_N=7)
  - flag_op enum
  - br_cond selector constants
  - mask bit positions
- One sub-module `nmi_edge`: sample flop, pending latch, ack. Everything else in `status_reg`.

## Test plan
- Reset for 2 cycles → p_out=8'h34, p_push with brk_push=0 → 8'h24, with brk_push=1 → 8'h34, both pendings 0.
- Issue ALU_ADD 8'h7F+8'h01, carry_in 0, upd_mask 4'b1111 at t → p_out=8'hF4 at t+2, unchanged at t+1.
- ALU result 8'h00, carry 1, mask 4'b1011, with SEC at t+1 → p_out Z=1, C=1, N=0, V unchanged. Then br_cond=3'b111 → br_taken=1; br_cond=3'b110 → br_taken=0.
- p_load with p_din=8'hC3 in the same cycle upd_q=1 (ALU result 8'h00) → p_out=8'hF3, Z from p_din (1).
- nmi_n high→low, held 5 cycles → nmi_pending=1 one cycle after the fall. nmi_ack clears it; no re-set until nmi_n goes high then low again.
- irq_n=0 with I=1 → irq_pending=0. CLI → irq_pending=1 two cycles after the CLI cycle. Reset mid-pending → 0.
